// File: rtl/dp_mem_responder.sv
// Cacheless memory responder: serializes datapath fetch and data requests onto one RAM port,
// returning registered single-cycle ihit/dhit pulses and retiring halt.
module dp_mem_responder #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        err,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WAIT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        DRSP,
        IRSP,
        HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic [31:0]   iload_q, iload_d;
    logic [31:0]   dload_q, dload_d;
    logic          ihit_q, ihit_d;
    logic          dhit_q, dhit_d;
    logic          flushed_q, flushed_d;
    logic          err_q, err_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            iload_q   <= '0;
            dload_q   <= '0;
            ihit_q    <= 1'b0;
            dhit_q    <= 1'b0;
            flushed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ren_q     <= ren_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            ihit_q    <= ihit_d;
            dhit_q    <= dhit_d;
            flushed_q <= flushed_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ren_d     = ren_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        store_d   = store_q;
        iload_d   = iload_q;
        dload_d   = dload_q;
        ihit_d    = 1'b0;
        dhit_d    = 1'b0;
        flushed_d = flushed_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d   = HALTED;
                    flushed_d = 1'b1;
                    ren_d     = 1'b0;
                    wen_d     = 1'b0;
                end else if (dmemREN || dmemWEN) begin
                    // A request with both enables set is treated as a store.
                    state_d = DACC;
                    addr_d  = dmemaddr;
                    store_d = dmemstore;
                    wen_d   = dmemWEN;
                    ren_d   = ~dmemWEN;
                    wait_d  = '0;
                end else if (imemREN) begin
                    state_d = IACC;
                    addr_d  = imemaddr;
                    store_d = dmemstore;
                    wen_d   = 1'b0;
                    ren_d   = 1'b1;
                    wait_d  = '0;
                end
            end
            DACC, IACC: begin
                if (ram_ready) begin
                    ren_d = 1'b0;
                    wen_d = 1'b0;
                    if (state_q == DACC) begin
                        if (!wen_q) dload_d = ramload;
                        dhit_d  = 1'b1;
                        state_d = DRSP;
                    end else begin
                        iload_d = ramload;
                        ihit_d  = 1'b1;
                        state_d = IRSP;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    // Abandon the access; the held request is re-arbitrated from IDLE.
                    err_d   = 1'b1;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    state_d = IDLE;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRSP, IRSP: begin
                state_d = IDLE;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign imemload = iload_q;
    assign dmemload = dload_q;
    assign flushed  = flushed_q;
    assign err      = err_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Self-checking bench for dp_mem_responder: a behavioural RAM plus a timeline model of
// when enables and hits must appear for each request, with directed and random scenarios.
module tb_dp_mem_responder;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
    logic [31:0] imemaddr = '0, dmemaddr = '0, dmemstore = '0;
    logic        ihit, dhit, flushed, err, ramREN, ramWEN;
    logic [31:0] imemload, dmemload, ramaddr, ramstore;
    logic [31:0] ramload = '0;
    logic        ram_ready = 1'b0;

    dp_mem_responder #(.TIMEOUT(TO)) dut (
        .CLK(clk), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .halt(halt),
        .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .flushed(flushed), .err(err),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural RAM (mem) and the bench's independent view of its contents (ref_mem).
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_dl = '0;
    logic [31:0] exp_il = '0;
    int          ram_lat = 0;
    bit          ready_en = 1'b1;
    int          busy = 0;

    // RAM answers ram_lat cycles after the enables first appear, shortly after each edge.
    always @(posedge clk) begin
        if (ramWEN && ram_ready) mem[ramaddr[9:2]] = ramstore;
        #2;
        if ((ramREN || ramWEN) && nRST) begin
            ram_ready = ready_en && (busy == ram_lat);
            ramload   = ram_ready ? mem[ramaddr[9:2]] : 32'h0;
            busy++;
        end else begin
            busy      = 0;
            ram_ready = 1'b0;
            ramload   = 32'h0;
        end
    end

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({ihit, dhit, flushed, err, ramREN, ramWEN} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got=%b want=000000", {ihit, dhit, flushed, err, ramREN, ramWEN});
        end
        n_vec++;
        if ({ramaddr, ramstore, imemload, dmemload} !== 128'h0) begin
            n_err++; $display("FAIL reset_buses got=%h want=0", {ramaddr, ramstore, imemload, dmemload});
        end
        nRST = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({ihit, dhit, flushed, err, ramREN, ramWEN} !== 6'b0) begin
            n_err++; $display("FAIL reset_idle got=%b want=000000", {ihit, dhit, flushed, err, ramREN, ramWEN});
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_fetch_only();
        ram_lat  = 0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        @(negedge clk);
        n_vec++;
        if ({ramREN, ramWEN, ihit} !== 3'b100) begin
            n_err++; $display("FAIL fetch_c1_en got=%b want=100", {ramREN, ramWEN, ihit});
        end
        n_vec++;
        if (ramaddr !== 32'h40) begin
            n_err++; $display("FAIL fetch_c1_addr got=%h want=00000040", ramaddr);
        end
        @(negedge clk);
        exp_il = 32'h8C220004;
        n_vec++;
        if ({ihit, dhit, ramREN} !== 3'b100) begin
            n_err++; $display("FAIL fetch_c2_hit got=%b want=100", {ihit, dhit, ramREN});
        end
        n_vec++;
        if (imemload !== exp_il) begin
            n_err++; $display("FAIL fetch_c2_load got=%h want=%h", imemload, exp_il);
        end
        imemREN = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ihit, ramREN} !== 2'b00) begin
            n_err++; $display("FAIL fetch_c3_quiet got=%b want=00", {ihit, ramREN});
        end
        $display("fetch_only: addr=00000040 load=%h", imemload);
    endtask

    task automatic test_simultaneous();
        int lat, dh, ih;
        lat = 1;
        dh  = lat + 2;
        ih  = dh + 3 + lat;
        ram_lat  = lat;
        imemREN  = 1'b1; imemaddr = 32'h44;
        dmemREN  = 1'b1; dmemaddr = 32'h100;
        for (int c = 1; c <= ih + 1; c++) begin
            @(negedge clk);
            n_vec++;
            if (dhit !== (c == dh) || ihit !== (c == ih)) begin
                n_err++; $display("FAIL simul_hits c=%0d got ihit=%b dhit=%b want ihit=%b dhit=%b",
                                  c, ihit, dhit, c == ih, c == dh);
            end
            n_vec++;
            if (ramREN !== ((c >= 1 && c <= lat + 1) || (c >= dh + 2 && c <= dh + 2 + lat))) begin
                n_err++; $display("FAIL simul_ren c=%0d got=%b", c, ramREN);
            end
            if (c == dh) begin
                exp_dl = ref_mem[64];
                n_vec++;
                if (dmemload !== exp_dl) begin
                    n_err++; $display("FAIL simul_dload got=%h want=%h", dmemload, exp_dl);
                end
                dmemREN = 1'b0;
            end
            if (c == ih) begin
                exp_il = ref_mem[17];
                n_vec++;
                if (imemload !== exp_il) begin
                    n_err++; $display("FAIL simul_iload got=%h want=%h", imemload, exp_il);
                end
                imemREN = 1'b0;
            end
        end
        $display("simultaneous: data 00000100 then fetch 00000044");
    endtask

    task automatic test_store();
        ram_lat   = 3;
        dmemREN   = 1'b1; dmemWEN = 1'b1;
        dmemaddr  = 32'h200; dmemstore = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_vec++;
            if ({ramWEN, ramREN, dhit} !== 3'b100 || ramaddr !== 32'h200 || ramstore !== 32'hDEADBEEF) begin
                n_err++; $display("FAIL store_hold c=%0d got wen/ren/dhit=%b addr=%h data=%h",
                                  c, {ramWEN, ramREN, dhit}, ramaddr, ramstore);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({dhit, ramWEN} !== 2'b10 || dmemload !== exp_dl) begin
            n_err++; $display("FAIL store_hit got dhit/wen=%b dmemload=%h want 10 %h", {dhit, ramWEN}, dmemload, exp_dl);
        end
        ref_mem[128] = 32'hDEADBEEF;
        dmemREN = 1'b0; dmemWEN = 1'b0;
        @(negedge clk);
        ram_lat = 0;
        dmemREN = 1'b1;
        repeat (2) @(negedge clk);
        exp_dl = ref_mem[128];
        n_vec++;
        if (dhit !== 1'b1 || dmemload !== exp_dl) begin
            n_err++; $display("FAIL store_readback got dhit=%b data=%h want 1 %h", dhit, dmemload, exp_dl);
        end
        dmemREN = 1'b0;
        @(negedge clk);
        $display("store: 00000200 <= deadbeef, read back %h", dmemload);
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            int kind, lat, h1, h2, ihc, last;
            bit has_d, has_f, is_w, in1, in2;
            logic [31:0] ia, da, ds, ea;
            kind  = $urandom_range(0, 4);
            lat   = $urandom_range(0, 3);
            has_d = (kind != 0);
            has_f = (kind == 0) || (kind >= 3);
            is_w  = (kind == 2) || (kind == 4);
            ia    = 32'($urandom_range(0, 15)) << 2;
            da    = 32'($urandom_range(0, 15)) << 2;
            ds    = $urandom;
            h1    = lat + 2;
            h2    = (has_d && has_f) ? h1 + 3 + lat : -1;
            ihc   = has_d ? h2 : h1;
            last  = (h2 > 0) ? h2 : h1;
            ram_lat   = lat;
            imemREN   = has_f; imemaddr = ia;
            dmemWEN   = is_w;
            dmemREN   = has_d && (!is_w || ($urandom_range(0, 1) == 1));
            dmemaddr  = da; dmemstore = ds;
            for (int c = 1; c <= last + 1; c++) begin
                @(negedge clk);
                in1 = (c <= lat + 1);
                in2 = (h2 > 0) && (c >= h1 + 2) && (c <= h1 + 2 + lat);
                ea  = in2 ? ia : (has_d ? da : ia);
                n_vec++;
                if (ramREN !== ((in1 && !is_w) || in2) || ramWEN !== (in1 && is_w)) begin
                    n_err++; $display("FAIL rand_en t=%0d c=%0d got ren=%b wen=%b", t, c, ramREN, ramWEN);
                end
                n_vec++;
                if (dhit !== (has_d && c == h1) || ihit !== (has_f && c == ihc)) begin
                    n_err++; $display("FAIL rand_hit t=%0d c=%0d got ihit=%b dhit=%b", t, c, ihit, dhit);
                end
                if (in1 || in2) begin
                    n_vec++;
                    if (ramaddr !== ea || (in1 && is_w && ramstore !== ds)) begin
                        n_err++; $display("FAIL rand_addr t=%0d c=%0d got addr=%h data=%h want %h %h",
                                          t, c, ramaddr, ramstore, ea, ds);
                    end
                end
                if (has_d && c == h1) begin
                    if (!is_w) exp_dl = ref_mem[da[9:2]];
                    n_vec++;
                    if (dmemload !== exp_dl) begin
                        n_err++; $display("FAIL rand_dload t=%0d got=%h want=%h", t, dmemload, exp_dl);
                    end
                    if (is_w) ref_mem[da[9:2]] = ds;
                    dmemREN = 1'b0; dmemWEN = 1'b0;
                end
                if (has_f && c == ihc) begin
                    exp_il = ref_mem[ia[9:2]];
                    n_vec++;
                    if (imemload !== exp_il) begin
                        n_err++; $display("FAIL rand_iload t=%0d got=%h want=%h", t, imemload, exp_il);
                    end
                    imemREN = 1'b0;
                end
            end
            $display("rand %0d: kind=%0d lat=%0d ia=%h da=%h ds=%h", t, kind, lat, ia, da, ds);
        end
    endtask

    task automatic test_timeout();
        ready_en = 1'b0;
        dmemREN  = 1'b1; dmemaddr = 32'h80;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            n_vec++;
            if ({ramREN, err, dhit} !== 3'b100) begin
                n_err++; $display("FAIL timeout_wait c=%0d got ren/err/dhit=%b want=100", c, {ramREN, err, dhit});
            end
        end
        @(negedge clk);
        n_vec++;
        if ({ramREN, err, dhit} !== 3'b010) begin
            n_err++; $display("FAIL timeout_abort got ren/err/dhit=%b want=010", {ramREN, err, dhit});
        end
        ready_en = 1'b1; ram_lat = 0;
        @(negedge clk);
        n_vec++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin
            n_err++; $display("FAIL timeout_retry got ren=%b addr=%h want 1 00000080", ramREN, ramaddr);
        end
        @(negedge clk);
        exp_dl = ref_mem[32];
        n_vec++;
        if ({dhit, err} !== 2'b11 || dmemload !== exp_dl) begin
            n_err++; $display("FAIL timeout_hit got dhit/err=%b data=%h want 11 %h", {dhit, err}, dmemload, exp_dl);
        end
        dmemREN = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({dhit, err} !== 2'b01) begin
            n_err++; $display("FAIL timeout_sticky got dhit/err=%b want=01", {dhit, err});
        end
        $display("timeout: abort after %0d cycles, retried", TO);
    endtask

    task automatic test_halt();
        ram_lat = 2;
        dmemREN = 1'b1; dmemaddr = 32'h10;
        @(negedge clk);
        halt = 1'b1; imemREN = 1'b1; imemaddr = 32'h20;
        repeat (3) @(negedge clk);
        exp_dl = ref_mem[4];
        n_vec++;
        if (dhit !== 1'b1 || dmemload !== exp_dl || flushed !== 1'b0) begin
            n_err++; $display("FAIL halt_dhit got dhit=%b data=%h flushed=%b want 1 %h 0", dhit, dmemload, flushed, exp_dl);
        end
        dmemREN = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ramREN, ramWEN, flushed, ihit, dhit} !== 5'b0) begin
            n_err++; $display("FAIL halt_idle got=%b want=00000", {ramREN, ramWEN, flushed, ihit, dhit});
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if ({flushed, ramREN, ramWEN, ihit, dhit} !== 5'b10000) begin
                n_err++; $display("FAIL halted c=%0d got=%b want=10000", c, {flushed, ramREN, ramWEN, ihit, dhit});
            end
        end
        $display("halt: dhit issued, then flushed with fetch held");
    endtask

    task automatic test_async_reset();
        nRST = 1'b0; halt = 1'b0; imemREN = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        exp_il = '0; exp_dl = '0;
        @(negedge clk);
        ram_lat = 5;
        imemREN = 1'b1; imemaddr = 32'h20;
        @(negedge clk);
        n_vec++;
        if (ramREN !== 1'b1) begin
            n_err++; $display("FAIL areset_iacc got ren=%b want=1", ramREN);
        end
        @(negedge clk);
        #2 nRST = 1'b0;
        #1;
        n_vec++;
        if ({ihit, dhit, flushed, err, ramREN, ramWEN} !== 6'b0 ||
            {ramaddr, ramstore, imemload, dmemload} !== 128'h0) begin
            n_err++; $display("FAIL areset_now got flags=%b addr=%h", {ihit, dhit, flushed, err, ramREN, ramWEN}, ramaddr);
        end
        imemREN = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_vec++;
            if ({ihit, ramREN, err} !== 3'b000) begin
                n_err++; $display("FAIL areset_after c=%0d got ihit/ren/err=%b want=000", c, {ihit, ramREN, err});
            end
        end
        $display("async_reset: cleared mid-fetch, no ihit");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
            ref_mem[i] = (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
        end
        mem[16]     = 32'h8C220004;
        ref_mem[16] = 32'h8C220004;
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_random(40);
        test_timeout();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
